id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- Decode-to-execute boundary of the 5-stage RV32I pipeline.
- Sits directly downstream of the opcode control decoder. Registers its control bundle together with the ID-stage operands into the EX stage.
- Owns load-use hazard detection (stall and bubble), branch/jump flush, and halt (ECALL/EBREAK/FENCE) freeze.
- Feeds the ALU, forwarding unit and EX/MEM register.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.
- CNT_W, 32, width of stall/flush event counters.

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write, id_branch, id_jal, id_jalr, id_auipc, id_halt, id_lui  in  1 each  decoder control bits
- id_alu_op  in  2  decoder ALU class
- id_pc  in  XLEN  PC of ID instruction
- id_rs1_data, id_rs2_data, id_imm  in  XLEN  register-file reads and immediate
- id_rs1, id_rs2, id_rd  in  RA_W  register addresses
- id_funct3  in  3  instruction[14:12]
- id_funct7b5  in  1  instruction[30]
- flush  in  1  taken branch/jump resolved downstream; kill ID and ID/EX contents
- stall  out  1  hold PC and IF/ID this cycle
- ex_* (one output per id_* input above)  out  same width  registered copies
- halted  out  1  sticky; core frozen
- stall_cnt, flush_cnt  out  CNT_W  event counters

Behaviour:
- Reset: all ex_* = 0, halted = 0, both counters = 0. stall is combinational from state and is therefore 0 right after reset.
- Bubble: all ex_* control bits = 0 and ex_alu_op = 0. Data fields (pc, operands, addresses, funct) still capture the ID inputs. A bubble is never allowed to write or branch.
- Source usage:
  - uses_rs1 = !(id_lui | id_jal | id_auipc | id_halt)
  - uses_rs2 = (!id_alu_src & !id_jal & !id_auipc & !id_halt) | id_mem_write
- Load-use condition (lu): ex_mem_read & ex_rd != 0 & ((uses_rs1 & ex_rd == id_rs1) | (uses_rs2 & ex_rd == id_rs2)).
- stall = !flush & (lu | ex_halt | halted).
- Per-edge priority, first matching rule wins:
  1. rst: reset values.
  2. flush: load bubble. flush_cnt increments. This cancels any halt currently in ID/EX, and halted does not set.
  3. halted or ex_halt: load bubble. When ex_halt = 1 and flush = 0, halted <= 1.
  4. lu: load bubble. stall_cnt increments.
  5. Otherwise: capture every id_* input into ex_*.
- Latency: exactly one cycle from ID to EX with no stall.
- A load-use stall lasts exactly one cycle. The bubble clears ex_mem_read, so lu falls the next cycle.
- Halt is the only stable state. halted clears only on rst.
- Counters saturate at all-ones; they never wrap.
- x0 destination never triggers a stall.
- Decoder don't-care bits (e.g. mem_to_reg on stores) are captured as driven; bubbles force 0.
- rst asserted mid-stall or mid-halt returns to reset values on that edge. stall drops in the same cycle.
- flush and lu in the same cycle: flush wins, stall = 0, and stall_cnt does not increment.

Decomposition:
- Shared package riscv_pkg:
  - ALU_OP_MEM = 2'b00, ALU_OP_BR = 2'b01, ALU_OP_R = 2'b10, ALU_OP_I = 2'b11
  - opcode[6:2] constants
  - a packed ctrl_t struct of the 12 control fields (including alu_op), so the bubble is ctrl_t'0
- One sub-module, hazard_detect: purely combinational. Computes uses_rs1/uses_rs2 and lu. It is reused later by the forwarding unit.
- The register and counters live in id_ex_stage_reg itself.

Test Plan:
1. Reset then normal flow: rst held 2 cycles, then ID presents ADD (reg_write = 1, alu_op = 10, rs1 = 1, rs2 = 2, rd = 3, pc = 0x10). Expect next cycle ex_reg_write = 1, ex_alu_op = 10, ex_rd = 3, ex_pc = 0x10, stall = 0.
2. Load-use: LW rd = 5, then ADD rs1 = 5. Expect stall = 1 for one cycle and bubble in EX (ex_reg_write = 0). The ADD is captured next, stall_cnt = 1. Repeat with rd = 0: no stall.
3. Store rs2 dependency: LW rd = 7, then SW rs2 = 7 (alu_src = 1, mem_write = 1). Expect a one-cycle stall. LUI rd = 9 after LW rd = 9: no stall.
4. Flush vs stall: load-use condition present and flush = 1 in the same cycle. Expect stall = 0, bubble captured, flush_cnt = 1, stall_cnt unchanged.
5. Halt: ECALL (halt = 1) enters EX. Expect stall = 1 immediately, halted = 1 the next cycle, and ex_* bubbles thereafter. Then 10 idle cycles: halted stays 1. rst clears halted to 0.
6. Halt cancelled: ECALL in ID/EX while flush = 1. Expect halted to stay 0, ex_halt = 0 next cycle, flow resumes.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU operation classes, opcode[6:2] values and the
// decoded control bundle that travels down the pipeline.
package riscv_pkg;

  localparam logic [1:0] ALU_OP_MEM = 2'b00;
  localparam logic [1:0] ALU_OP_BR  = 2'b01;
  localparam logic [1:0] ALU_OP_R   = 2'b10;
  localparam logic [1:0] ALU_OP_I   = 2'b11;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  // All-zero value of this struct is the pipeline bubble.
  typedef struct packed {
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       auipc;
    logic       halt;
    logic       lui;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: decides which sources the ID instruction
// reads and whether a load sitting in EX produces one of them.
module hazard_detect
  import riscv_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            id_lui,
  input  logic            id_jal,
  input  logic            id_auipc,
  input  logic            id_halt,
  input  logic            id_alu_src,
  input  logic            id_mem_write,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] ex_rd,
  output logic            uses_rs1,
  output logic            uses_rs2,
  output logic            lu
);

  logic rs1_hit;
  logic rs2_hit;

  assign uses_rs1 = !(id_lui | id_jal | id_auipc | id_halt);
  // Stores read rs2 as write data even though the ALU takes the immediate.
  assign uses_rs2 = (!id_alu_src & !id_jal & !id_auipc & !id_halt) | id_mem_write;

  assign rs1_hit = uses_rs1 & (ex_rd == id_rs1);
  assign rs2_hit = uses_rs2 & (ex_rd == id_rs2);
  assign lu      = ex_mem_read & (ex_rd != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall, flush bubble, sticky halt
// freeze and saturating stall/flush event counters.
module id_ex_stage_reg
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_mem_read,
  input  logic            id_mem_to_reg,
  input  logic            id_mem_write,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_branch,
  input  logic            id_jal,
  input  logic            id_jalr,
  input  logic            id_auipc,
  input  logic            id_halt,
  input  logic            id_lui,
  input  logic [1:0]      id_alu_op,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic            flush,
  output logic            stall,
  output logic            ex_mem_read,
  output logic            ex_mem_to_reg,
  output logic            ex_mem_write,
  output logic            ex_alu_src,
  output logic            ex_reg_write,
  output logic            ex_branch,
  output logic            ex_jal,
  output logic            ex_jalr,
  output logic            ex_auipc,
  output logic            ex_halt,
  output logic            ex_lui,
  output logic [1:0]      ex_alu_op,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic [RA_W-1:0] ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_t           id_ctrl;
  ctrl_t           ctrl_reg;
  ctrl_t           ctrl_next;
  logic            halted_reg;
  logic            lu;
  logic            uses_rs1;
  logic            uses_rs2;
  logic            freeze;
  logic [1:0]      cnt_evt;
  logic [CNT_W-1:0] cnt_q [2];

  assign id_ctrl = {id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write,
                    id_branch, id_jal, id_jalr, id_auipc, id_halt, id_lui, id_alu_op};

  hazard_detect #(.RA_W(RA_W)) u_hazard (
    .id_lui       (id_lui),
    .id_jal       (id_jal),
    .id_auipc     (id_auipc),
    .id_halt      (id_halt),
    .id_alu_src   (id_alu_src),
    .id_mem_write (id_mem_write),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_mem_read  (ctrl_reg.mem_read),
    .ex_rd        (ex_rd),
    .uses_rs1     (uses_rs1),
    .uses_rs2     (uses_rs2),
    .lu           (lu)
  );

  assign freeze    = halted_reg | ctrl_reg.halt;
  assign stall     = !flush & (lu | freeze);
  assign ctrl_next = (flush | freeze | lu) ? ctrl_t'('0) : id_ctrl;

  // Flush outranks the halt freeze, which outranks load-use; only the winning rule counts.
  assign cnt_evt[0] = !flush & !freeze & lu;
  assign cnt_evt[1] = flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_reg    <= '0;
      halted_reg  <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
    end else begin
      ctrl_reg    <= ctrl_next;
      if (!flush && ctrl_reg.halt) begin
        halted_reg <= 1'b1;
      end
      // Data fields follow ID even into a bubble; only control is squashed.
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct3   <= id_funct3;
      ex_funct7b5 <= id_funct7b5;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (cnt_evt[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      assign cnt_q[gi] = cnt_reg;
    end
  endgenerate

  assign stall_cnt     = cnt_q[0];
  assign flush_cnt     = cnt_q[1];
  assign halted        = halted_reg;
  assign ex_mem_read   = ctrl_reg.mem_read;
  assign ex_mem_to_reg = ctrl_reg.mem_to_reg;
  assign ex_mem_write  = ctrl_reg.mem_write;
  assign ex_alu_src    = ctrl_reg.alu_src;
  assign ex_reg_write  = ctrl_reg.reg_write;
  assign ex_branch     = ctrl_reg.branch;
  assign ex_jal        = ctrl_reg.jal;
  assign ex_jalr       = ctrl_reg.jalr;
  assign ex_auipc      = ctrl_reg.auipc;
  assign ex_halt       = ctrl_reg.halt;
  assign ex_lui        = ctrl_reg.lui;
  assign ex_alu_op     = ctrl_reg.alu_op;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed table of pipeline scenarios, then random
// traffic and counter saturation runs against a rule-level reference model.
module tb_id_ex_stage_reg;
  import riscv_pkg::*;

  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam int CW   = 4;  // narrow counters so saturation is reachable
  localparam int K_NOP = 0, K_ADD = 1, K_LW = 2, K_SW = 3, K_LUI = 4, K_ECALL = 5;

  typedef struct packed {
    logic rst, flush;
    logic mem_read, mem_to_reg, mem_write, alu_src, reg_write, branch, jal, jalr, auipc, halt, lui;
    logic [1:0] alu_op;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] funct3;
    logic funct7b5;
  } in_t;

  typedef struct {
    in_t v;
    bit cs;
    logic es;
    logic [50:0] eo;
  } row_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, stall, halted;
  logic id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write, id_branch;
  logic id_jal, id_jalr, id_auipc, id_halt, id_lui, id_funct7b5;
  logic [1:0] id_alu_op;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_funct3;
  logic ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_branch;
  logic ex_jal, ex_jalr, ex_auipc, ex_halt, ex_lui, ex_funct7b5;
  logic [1:0] ex_alu_op;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  logic [CW-1:0] stall_cnt, flush_cnt;

  id_ex_stage_reg #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_branch(id_branch),
    .id_jal(id_jal), .id_jalr(id_jalr), .id_auipc(id_auipc), .id_halt(id_halt),
    .id_lui(id_lui), .id_alu_op(id_alu_op), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .flush(flush),
    .stall(stall),
    .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_branch(ex_branch),
    .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_auipc(ex_auipc), .ex_halt(ex_halt),
    .ex_lui(ex_lui), .ex_alu_op(ex_alu_op), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  row_t rows[$];

  // Reference model state: what EX should hold, plus halt flag and event counts.
  in_t m_ex;
  logic m_halted;
  int m_sc, m_fc;

  task automatic check(input string nm, input logic [199:0] act, input logic [199:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic in_t mk(int k, int r1, int r2, int d, int pc, bit rs = 0, bit fl = 0);
    in_t v = '0;
    v.rst = rs; v.flush = fl;
    v.rs1 = 5'(r1); v.rs2 = 5'(r2); v.rd = 5'(d);
    v.pc = 32'(pc);
    v.rs1_data = 32'hA000_0000 | 32'(pc);
    v.rs2_data = 32'hB000_0000 ^ 32'(pc);
    v.imm = 32'(pc) << 2;
    v.funct3 = 3'(k);
    v.funct7b5 = (k == K_SW);
    case (k)
      K_NOP:   begin v.reg_write = 1; v.alu_src = 1; v.alu_op = ALU_OP_I; end
      K_ADD:   begin v.reg_write = 1; v.alu_op = ALU_OP_R; end
      K_LW:    begin v.mem_read = 1; v.mem_to_reg = 1; v.alu_src = 1; v.reg_write = 1; v.alu_op = ALU_OP_MEM; end
      K_SW:    begin v.mem_write = 1; v.alu_src = 1; v.alu_op = ALU_OP_MEM; end
      K_LUI:   begin v.lui = 1; v.alu_src = 1; v.reg_write = 1; v.alu_op = ALU_OP_I; end
      default: begin v.halt = 1; end
    endcase
    return v;
  endfunction

  function automatic logic [50:0] eo(bit rw, bit mr, bit h, int aop, int rd, int pc, bit hd, int sc, int fc);
    return {rw, mr, h, 2'(aop), 5'(rd), 32'(pc), hd, 4'(sc), 4'(fc)};
  endfunction

  task automatic add(input in_t v, input bit cs, input logic es, input logic [50:0] e);
    row_t r;
    r.v = v; r.cs = cs; r.es = es; r.eo = e;
    rows.push_back(r);
  endtask

  task automatic drive(input in_t v);
    rst = v.rst; flush = v.flush;
    id_mem_read = v.mem_read; id_mem_to_reg = v.mem_to_reg; id_mem_write = v.mem_write;
    id_alu_src = v.alu_src; id_reg_write = v.reg_write; id_branch = v.branch;
    id_jal = v.jal; id_jalr = v.jalr; id_auipc = v.auipc; id_halt = v.halt; id_lui = v.lui;
    id_alu_op = v.alu_op; id_pc = v.pc; id_rs1_data = v.rs1_data; id_rs2_data = v.rs2_data;
    id_imm = v.imm; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
    id_funct3 = v.funct3; id_funct7b5 = v.funct7b5;
  endtask

  function automatic in_t get_ex();
    in_t a = '0;
    a.mem_read = ex_mem_read; a.mem_to_reg = ex_mem_to_reg; a.mem_write = ex_mem_write;
    a.alu_src = ex_alu_src; a.reg_write = ex_reg_write; a.branch = ex_branch;
    a.jal = ex_jal; a.jalr = ex_jalr; a.auipc = ex_auipc; a.halt = ex_halt; a.lui = ex_lui;
    a.alu_op = ex_alu_op; a.pc = ex_pc; a.rs1_data = ex_rs1_data; a.rs2_data = ex_rs2_data;
    a.imm = ex_imm; a.rs1 = ex_rs1; a.rs2 = ex_rs2; a.rd = ex_rd;
    a.funct3 = ex_funct3; a.funct7b5 = ex_funct7b5;
    return a;
  endfunction

  function automatic in_t bubble(in_t x);
    in_t b = x;
    {b.mem_read, b.mem_to_reg, b.mem_write, b.alu_src, b.reg_write, b.branch} = '0;
    {b.jal, b.jalr, b.auipc, b.halt, b.lui, b.alu_op} = '0;
    return b;
  endfunction

  // Does the instruction in ID need a register that the load in EX has not produced yet?
  function automatic logic mdl_lu(in_t v);
    logic needs1 = !(v.lui || v.jal || v.auipc || v.halt);
    logic needs2 = (!v.alu_src && !v.jal && !v.auipc && !v.halt) || v.mem_write;
    if (!m_ex.mem_read || m_ex.rd == 0) return 1'b0;
    return (needs1 && m_ex.rd == v.rs1) || (needs2 && m_ex.rd == v.rs2);
  endfunction

  function automatic logic mdl_stall(in_t v);
    return !v.flush && (mdl_lu(v) || m_ex.halt || m_halted);
  endfunction

  task automatic model_step(input in_t v);
    in_t nx = v;
    nx.rst = 0; nx.flush = 0;
    if (v.rst) begin
      m_ex = '0; m_halted = 0; m_sc = 0; m_fc = 0;
    end else if (v.flush) begin
      m_ex = bubble(nx); m_fc = (m_fc < 15) ? m_fc + 1 : 15;
    end else if (m_halted || m_ex.halt) begin
      m_ex = bubble(nx); m_halted = 1;
    end else if (mdl_lu(v)) begin
      m_ex = bubble(nx); m_sc = (m_sc < 15) ? m_sc + 1 : 15;
    end else begin
      m_ex = nx;
    end
  endtask

  task automatic run_cycle(input in_t v, output logic st_act, output logic st_exp);
    drive(v);
    #2;
    st_act = stall;
    st_exp = mdl_stall(v);
    model_step(v);
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input in_t v, input string nm);
    logic sa, se;
    run_cycle(v, sa, se);
    check({nm, "_stall"}, 200'(sa), 200'(se));
    check({nm, "_ex"}, 200'({get_ex(), halted, stall_cnt, flush_cnt}),
          200'({m_ex, m_halted, 4'(m_sc), 4'(m_fc)}));
  endtask

  function automatic in_t rnd_in();
    in_t v;
    logic [31:0] r = $urandom;
    int k = ($urandom_range(0, 19) == 0) ? K_ECALL : int'($urandom_range(0, 4));
    v = mk(k, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    if (r[31]) begin
      {v.mem_read, v.mem_to_reg, v.mem_write, v.alu_src, v.reg_write, v.branch} = r[5:0];
      {v.jal, v.jalr, v.auipc, v.lui, v.alu_op} = r[11:6];
      v.halt = ($urandom_range(0, 19) == 0);
      v.rs1_data = $urandom; v.rs2_data = $urandom; v.imm = $urandom;
      v.funct3 = r[14:12]; v.funct7b5 = r[15];
    end
    v.flush = ($urandom_range(0, 7) == 0);
    v.rst = ($urandom_range(0, 149) == 0);
    return v;
  endfunction

  initial begin
    in_t v;
    logic sa, se;
    m_ex = '0; m_halted = 0; m_sc = 0; m_fc = 0;

    // Reset, normal flow, load-use on rs1 and on store rs2, x0 and LUI exemptions
    add(mk(K_NOP, 0, 0, 0, 0, 1), 0, 0, eo(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk(K_ADD, 1, 2, 3, 'h10, 1), 1, 0, eo(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk(K_ADD, 1, 2, 3, 'h10), 1, 0, eo(1, 0, 0, 2, 3, 'h10, 0, 0, 0));
    add(mk(K_LW, 1, 0, 5, 'h14), 1, 0, eo(1, 1, 0, 0, 5, 'h14, 0, 0, 0));
    add(mk(K_ADD, 5, 2, 6, 'h18), 1, 1, eo(0, 0, 0, 0, 6, 'h18, 0, 1, 0));
    add(mk(K_ADD, 5, 2, 6, 'h18), 1, 0, eo(1, 0, 0, 2, 6, 'h18, 0, 1, 0));
    add(mk(K_LW, 1, 0, 0, 'h1c), 1, 0, eo(1, 1, 0, 0, 0, 'h1c, 0, 1, 0));
    add(mk(K_ADD, 0, 0, 4, 'h20), 1, 0, eo(1, 0, 0, 2, 4, 'h20, 0, 1, 0));
    add(mk(K_LW, 1, 0, 7, 'h24), 1, 0, eo(1, 1, 0, 0, 7, 'h24, 0, 1, 0));
    add(mk(K_SW, 1, 7, 10, 'h28), 1, 1, eo(0, 0, 0, 0, 10, 'h28, 0, 2, 0));
    add(mk(K_SW, 1, 7, 10, 'h28), 1, 0, eo(0, 0, 0, 0, 10, 'h28, 0, 2, 0));
    add(mk(K_LW, 2, 0, 9, 'h2c), 1, 0, eo(1, 1, 0, 0, 9, 'h2c, 0, 2, 0));
    add(mk(K_LUI, 9, 9, 9, 'h30), 1, 0, eo(1, 0, 0, 3, 9, 'h30, 0, 2, 0));
    // Flush beats a simultaneous load-use
    add(mk(K_LW, 1, 0, 8, 'h34), 1, 0, eo(1, 1, 0, 0, 8, 'h34, 0, 2, 0));
    add(mk(K_ADD, 8, 0, 10, 'h38, 0, 1), 1, 0, eo(0, 0, 0, 0, 10, 'h38, 0, 2, 1));
    add(mk(K_ADD, 8, 0, 10, 'h3c), 1, 0, eo(1, 0, 0, 2, 10, 'h3c, 0, 2, 1));
    // Halt freeze, held across idle cycles, cleared only by reset
    add(mk(K_ECALL, 0, 0, 0, 'h40), 1, 0, eo(0, 0, 1, 0, 0, 'h40, 0, 2, 1));
    add(mk(K_ADD, 1, 2, 11, 'h44), 1, 1, eo(0, 0, 0, 0, 11, 'h44, 1, 2, 1));
    for (int i = 0; i < 10; i++)
      add(mk(K_ADD, 1, 2, 11, 'h44), 1, 1, eo(0, 0, 0, 0, 11, 'h44, 1, 2, 1));
    add(mk(K_ADD, 1, 2, 11, 'h44, 1), 1, 1, eo(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Halt cancelled by flush while in EX
    add(mk(K_ADD, 1, 2, 3, 'h50), 1, 0, eo(1, 0, 0, 2, 3, 'h50, 0, 0, 0));
    add(mk(K_ECALL, 0, 0, 0, 'h54), 1, 0, eo(0, 0, 1, 0, 0, 'h54, 0, 0, 0));
    add(mk(K_ADD, 1, 2, 12, 'h58, 0, 1), 1, 0, eo(0, 0, 0, 0, 12, 'h58, 0, 0, 1));
    add(mk(K_ADD, 1, 2, 13, 'h5c), 1, 0, eo(1, 0, 0, 2, 13, 'h5c, 0, 0, 1));

    foreach (rows[i]) begin
      run_cycle(rows[i].v, sa, se);
      if (rows[i].cs) check($sformatf("row%0d_stall", i), 200'(sa), 200'(rows[i].es));
      check($sformatf("row%0d_ex", i),
            200'({ex_reg_write, ex_mem_read, ex_halt, ex_alu_op, ex_rd, ex_pc, halted, stall_cnt, flush_cnt}),
            200'(rows[i].eo));
    end

    for (int i = 0; i < 600; i++) begin
      v = rnd_in();
      if (m_halted && $urandom_range(0, 3) == 0) v.rst = 1;
      step_chk(v, $sformatf("rand%0d", i));
    end

    // Saturation of both counters
    step_chk(mk(K_NOP, 0, 0, 0, 0, 1), "sat_rst0");
    for (int i = 0; i < 20; i++) step_chk(mk(K_ADD, 1, 2, 3, 4 * i, 0, 1), "sat_fl");
    check("sat_flush_cnt", 200'(flush_cnt), 200'(15));
    step_chk(mk(K_NOP, 0, 0, 0, 0, 1), "sat_rst1");
    for (int i = 0; i < 20; i++) begin
      step_chk(mk(K_LW, 1, 0, 5, 'h100), "sat_lw");
      step_chk(mk(K_ADD, 5, 1, 6, 'h104), "sat_use");
      step_chk(mk(K_ADD, 5, 1, 6, 'h104), "sat_go");
    end
    check("sat_stall_cnt", 200'(stall_cnt), 200'(15));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
